debug_tx_serializer: RTL and testbench
======================================

Name: debug_tx_serializer

Overview:
Transmit-side companion of the debug unit's host link. It buffers 32-bit words written by the debug unit (register dump, latches, memory data/address pairs, "endd" marker) in an internal word FIFO. It serializes each word into 4 bytes, MSB first, and drives the UART transmitter with a start/done byte handshake. It sits between the debug unit's FIFO write port and the UART TX.

Parameters:
FIFO_DEPTH, 64, number of 32-bit word entries; power of two, at least 2.
END_WORD, 32'h656E6464 ("endd"), word that marks the end of a dump frame.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_data  in  32  word to enqueue
i_write_en  in  1  enqueue i_data on this edge; level-sensitive, one word per cycle while high
o_full  out  1  FIFO holds FIFO_DEPTH words
o_empty  out  1  FIFO holds 0 words
o_tx_data  out  8  byte presented to UART TX; stable from o_tx_start until i_tx_done
o_tx_start  out  1  one-cycle pulse: UART TX begins sending o_tx_data
i_tx_done  in  1  one-cycle tick: UART TX finished the current byte
o_busy  out  1  serializer is holding or sending a word (state != ST_IDLE)
o_overflow  out  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset values: o_tx_data=0, o_tx_start=0, o_busy=0, o_overflow=0, o_empty=1, o_full=0. Read/write pointers and count are cleared and the FSM returns to ST_IDLE. Reset mid-byte abandons the word; no further start pulse is issued.
- FIFO: count width is clog2(FIFO_DEPTH)+1 and pointers wrap modulo FIFO_DEPTH.
  - Write when i_write_en && (!o_full || pop in the same cycle).
  - A write with o_full=1 and no pop is dropped, and o_overflow is set until reset.
  - A simultaneous push and pop leaves count unchanged.
  - o_full and o_empty are registered and derived from the next-count value.
- FSM states:
  - ST_IDLE: if !o_empty, pop the head word into shift register sh[31:0], set byte_idx=0, go to ST_START.
  - ST_START: o_tx_data<=sh[31:24], o_tx_start<=1 for exactly one cycle, go to ST_WAIT.
  - ST_WAIT: hold o_tx_data. On i_tx_done:
    - if byte_idx==3, go to ST_IDLE;
    - otherwise sh<=sh<<8, byte_idx++, go to ST_START.
- i_tx_done outside ST_WAIT is ignored.
- Latency: the word is written at edge N into an empty FIFO with the FSM idle. It is popped at N+1, and o_tx_start is high in the cycle after edge N+2.
- Back-to-back words: the next pop happens in the ST_IDLE cycle after the 4th done, so there is one idle cycle between words.
- Byte order is MSB first, so "endd" goes out as 0x65,0x6E,0x64,0x64.
- The FSM is independent of frame content except in the optional feature below.

Optional Feature:
Macro DEBUG_TX_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator folds in every byte sent since reset or since the last checksum.
  - After the last byte of a word equal to END_WORD, the FSM enters ST_CSUM_START, which sends the accumulator value with the same start/done handshake via ST_CSUM_WAIT.
  - The accumulator clears after that byte's i_tx_done.
  - A frame ending "endd" therefore emits 4+1 bytes for the last word.
- Undefined: no accumulator, no extra states; END_WORD has no special meaning.

Test Plan:
1. Reset, write 32'h12345678 once, answer each o_tx_start with i_tx_done 10 cycles later -> bytes 0x12,0x34,0x56,0x78 in order; exactly 4 start pulses; o_tx_start first high 2 cycles after the write edge; o_busy drops after the 4th done; o_empty=1.
2. FIFO_DEPTH=4, hold i_write_en high 6 cycles with data 1..6 while i_tx_done is held off -> words 1 to 5 accepted (the 1st is popped into the shifter); 6 dropped; o_full=1; o_overflow=1. Then release done ticks -> 20 bytes of words 1 to 5 only.
3. With the FIFO full, write and pop in the same cycle -> write accepted, count unchanged, o_overflow stays 0.
4. Assert i_reset during ST_WAIT after byte 2 -> all outputs reach reset values next cycle; FIFO empty; no further o_tx_start until a new write.
5. Spurious i_tx_done while in ST_IDLE and ST_START -> ignored; byte sequence unchanged.
6. With DEBUG_TX_CHECKSUM_EN defined, write 32'h00000001 then 32'h656E6464 -> bytes 00,00,00,01,65,6E,64,64, then checksum 0x01^0x65^0x6E^0x64^0x64=0x0A. Undefined -> no 9th byte.

Source files
------------

// File: rtl/debug_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : debug_tx_serializer
//  Purpose  : Transmit side of the debug host link. 32-bit words from the
//             debug unit are buffered in a word FIFO. Each word is then sent
//             to the UART TX as 4 bytes, MSB first, using a start/done byte
//             handshake.
//  Options  : DEBUG_TX_CHECKSUM_EN - when defined, an XOR checksum byte is
//             sent after every word equal to END_WORD ("endd").
//  Revision : 1.0  initial release
// ============================================================================
module debug_tx_serializer #(
    parameter int          FIFO_DEPTH = 64,
    parameter logic [31:0] END_WORD   = 32'h656E6464
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_data,
    input  logic        i_write_en,
    output logic        o_full,
    output logic        o_empty,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_start,
    input  logic        i_tx_done,
    output logic        o_busy,
    output logic        o_overflow
);

    localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
`ifdef DEBUG_TX_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_WAIT       = 3'd2,
        ST_CSUM_START = 3'd3,
        ST_CSUM_WAIT  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;
`endif

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Word FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_overflow;

    logic            w_pop;
    logic            w_push;
    logic [c_CW-1:0] w_count_next;

    // ------------------------------------------------------------------
    // Serializer datapath
    // ------------------------------------------------------------------
    logic [31:0] r_sh;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_tx_data;
    logic        r_tx_start;
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0]  r_csum;
    logic        r_is_end;
`endif

    // The head word is consumed only while the FSM is idle; a push is
    // still allowed into a full FIFO when that same edge pops a word.
    assign w_pop  = (r_state == ST_IDLE) && !r_empty;
    assign w_push = i_write_en && (!r_full || w_pop);

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CW'(1);
        end
    end

    // FIFO storage write; contents need no reset because count gates reads.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // FIFO pointers, count, registered flags and sticky overflow.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_DEPTH_CNT);
            r_empty <= (w_count_next == '0);
            if (i_write_en && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; done ticks only matter in the wait states.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!r_empty) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (r_byte_idx == 2'd3) begin
`ifdef DEBUG_TX_CHECKSUM_EN
                        w_state_next = r_is_end ? ST_CSUM_START : ST_IDLE;
`else
                        w_state_next = ST_IDLE;
`endif
                    end else begin
                        w_state_next = ST_START;
                    end
                end
            end
`ifdef DEBUG_TX_CHECKSUM_EN
            ST_CSUM_START: begin
                w_state_next = ST_CSUM_WAIT;
            end
            ST_CSUM_WAIT: begin
                if (i_tx_done) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shift register, byte index, TX byte/start pulse and checksum.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh       <= '0;
            r_byte_idx <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
            r_csum     <= '0;
            r_is_end   <= 1'b0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_sh       <= r_mem[r_rd_ptr];
                        r_byte_idx <= 2'd0;
`ifdef DEBUG_TX_CHECKSUM_EN
                        r_is_end   <= (r_mem[r_rd_ptr] == END_WORD);
`endif
                    end
                end
                ST_START: begin
                    r_tx_data  <= r_sh[31:24];
                    r_tx_start <= 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
                    r_csum     <= r_csum ^ r_sh[31:24];
`endif
                end
                ST_WAIT: begin
                    if (i_tx_done && (r_byte_idx != 2'd3)) begin
                        r_sh       <= {r_sh[23:0], 8'h00};
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
`ifdef DEBUG_TX_CHECKSUM_EN
                ST_CSUM_START: begin
                    r_tx_data  <= r_csum;
                    r_tx_start <= 1'b1;
                end
                ST_CSUM_WAIT: begin
                    if (i_tx_done) begin
                        r_csum <= '0;
                    end
                end
`endif
                default: begin
                    r_tx_start <= 1'b0;
                end
            endcase
        end
    end

    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_overflow = r_overflow;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = (r_state != ST_IDLE);

`ifndef DEBUG_TX_CHECKSUM_EN
    // END_WORD only has meaning with the checksum feature.
    logic [31:0] w_end_word_unused;
    assign w_end_word_unused = END_WORD;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debug_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debug_tx_serializer
//  Purpose  : Scoreboard bench for debug_tx_serializer (FIFO_DEPTH=4).
//             Expected bytes are queued when words are issued; a monitor
//             compares every o_tx_start byte against the queue head.
//  Revision : 1.0  initial release
// ============================================================================
module tb_debug_tx_serializer;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic        we;
    logic        resp_done;
    logic        spur_done;
    logic        hold;
    logic        tx_done;
    logic        full, empty, tx_start, busy, ovf;
    logic [7:0]  tx_data;

    assign tx_done = resp_done | spur_done;

    debug_tx_serializer #(.FIFO_DEPTH(c_DEPTH)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_data     (data),
        .i_write_en (we),
        .o_full     (full),
        .o_empty    (empty),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .i_tx_done  (tx_done),
        .o_busy     (busy),
        .o_overflow (ovf)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         n_starts = 0;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;
    bit         resp_active = 1'b0;

    // Monitor: every start pulse is one transmitted byte.
    always @(negedge clk) begin
        if (tx_start) begin
            n_starts++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_start got=%02h want=none", tx_data);
            end else begin
                mon_exp = sb.pop_front();
                if (tx_data !== mon_exp) begin
                    bad++;
                    $display("FAIL tx_byte got=%02h want=%02h", tx_data, mon_exp);
                end
            end
        end
    end

    // UART model: done tick 10 cycles after each start, unless held off.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                resp_active = 1'b1;
                repeat (10) @(negedge clk);
                while (hold) @(negedge clk);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
                resp_active = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        sb.push_back(w[31:24]);
        sb.push_back(w[23:16]);
        sb.push_back(w[15:8]);
        sb.push_back(w[7:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        @(negedge clk);
        data = w;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, "_tx_data"}, {24'h0, tx_data}, 32'h0);
        chk({n, "_start"}, {31'h0, tx_start}, 32'h0);
        chk({n, "_busy"}, {31'h0, busy}, 32'h0);
        chk({n, "_ovf"}, {31'h0, ovf}, 32'h0);
        chk({n, "_empty"}, {31'h0, empty}, 32'h1);
        chk({n, "_full"}, {31'h0, full}, 32'h0);
    endtask

    task automatic drain(input string n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !resp_active) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_drain got=pending_%0d_bytes want=0", n, sb.size());
            sb.delete();
        end
    endtask

    int  s0;
    bit  found;

    initial begin
        rst = 1'b1; data = '0; we = 1'b0; spur_done = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single word, latency, byte order
        do_reset();
        chk_reset_vals("t1_reset");
        s0 = n_starts;
        push_word(32'h12345678);
        data = 32'h12345678;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        chk("t1_start_n0", {31'h0, tx_start}, 32'h0);
        @(negedge clk);
        chk("t1_start_n1", {31'h0, tx_start}, 32'h0);
        chk("t1_busy_n1", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("t1_start_n2", {31'h0, tx_start}, 32'h1);
        drain("t1", 2000);
        chk("t1_nstarts", n_starts - s0, 4);
        chk("t1_empty", {31'h0, empty}, 32'h1);
        chk("t1_busy_end", {31'h0, busy}, 32'h0);

        // 2: overflow with done held off
        do_reset();
        hold = 1'b1;
        s0 = n_starts;
        for (int i = 1; i <= 5; i++) push_word(i);
        we = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            data = i;
            @(negedge clk);
        end
        we = 1'b0;
        chk("t2_full", {31'h0, full}, 32'h1);
        chk("t2_ovf", {31'h0, ovf}, 32'h1);
        chk("t2_empty", {31'h0, empty}, 32'h0);
        hold = 1'b0;
        drain("t2", 4000);
        chk("t2_nbytes", n_starts - s0, 20);
        chk("t2_ovf_sticky", {31'h0, ovf}, 32'h1);

        // 3: push into full FIFO on the pop edge
        do_reset();
        hold = 1'b1;
        for (int i = 11; i <= 16; i++) push_word(i);
        we = 1'b1;
        for (int i = 11; i <= 15; i++) begin
            data = i;
            @(negedge clk);
        end
        we = 1'b0;
        chk("t3_full_pre", {31'h0, full}, 32'h1);
        hold = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        chk("t3_idle_seen", {31'h0, found}, 32'h1);
        data = 32'd16;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        chk("t3_full_post", {31'h0, full}, 32'h1);
        chk("t3_ovf", {31'h0, ovf}, 32'h0);
        drain("t3", 6000);
        chk("t3_ovf_end", {31'h0, ovf}, 32'h0);

        // 4: reset while waiting on byte 2
        do_reset();
        s0 = n_starts;
        sb.push_back(8'hAA);
        sb.push_back(8'hBB);
        write_word(32'hAABBCCDD);
        write_word(32'h11223344);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (n_starts - s0 == 2) found = 1'b1;
        end
        chk("t4_two_bytes", {31'h0, found}, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("t4_reset");
        repeat (60) @(negedge clk);
        chk("t4_no_more", n_starts - s0, 2);
        chk("t4_sb_empty", sb.size(), 0);
        sb.delete();

        // 5: spurious done in IDLE and START
        do_reset();
        s0 = n_starts;
        push_word(32'hCAFEF00D);
        data      = 32'hCAFEF00D;
        we        = 1'b1;
        spur_done = 1'b1;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        spur_done = 1'b0;
        drain("t5", 2000);
        chk("t5_nstarts", n_starts - s0, 4);

        // 6: back-to-back words ending in "endd"
        do_reset();
        s0 = n_starts;
        push_word(32'h00000001);
        push_word(32'h656E6464);
`ifdef DEBUG_TX_CHECKSUM_EN
        sb.push_back(8'h0A);
`endif
        @(negedge clk);
        data = 32'h00000001;
        we   = 1'b1;
        @(negedge clk);
        data = 32'h656E6464;
        @(negedge clk);
        we   = 1'b0;
        drain("t6", 4000);
`ifdef DEBUG_TX_CHECKSUM_EN
        chk("t6_nbytes", n_starts - s0, 9);
`else
        chk("t6_nbytes", n_starts - s0, 8);
`endif
        chk("t6_empty", {31'h0, empty}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
